// File: rtl/io_bridge_pkg.sv
// Shared types and default sizing for the peripheral-side CPU port bridge.
package io_bridge_pkg;

    localparam int unsigned DEFAULT_DATA_W     = 8;
    localparam int unsigned DEFAULT_FIFO_DEPTH = 4;

    // Interrupt handshake: request raised, then held in service while the CPU acks.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        SERV = 2'd2
    } intr_state_e;

endpackage

// File: rtl/io_out_fifo.sv
// Output queue for CPU port writes. DEPTH == 1 collapses to a holding register;
// larger depths use a ring buffer whose pointers carry one extra wrap bit.
module io_out_fifo #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic              full,
    output logic              empty,
    output logic [DATA_W-1:0] pop_data
);

    generate
        if (DEPTH == 1) begin : g_reg
            logic              valid_q, valid_d;
            logic [DATA_W-1:0] data_q, data_d;

            // A full register still accepts a write when it is drained in the same cycle.
            always_comb begin
                valid_d = valid_q;
                data_d  = data_q;
                if (pop && valid_q) begin
                    valid_d = 1'b0;
                end
                if (push && (!valid_q || pop)) begin
                    valid_d = 1'b1;
                    data_d  = push_data;
                end
            end

            // Holding register state.
            always_ff @(posedge clk) begin
                if (rst) begin
                    valid_q <= 1'b0;
                end else begin
                    valid_q <= valid_d;
                end
                data_q <= data_d;
            end

            assign full     = valid_q;
            assign empty    = ~valid_q;
            assign pop_data = data_q;
        end else begin : g_ring
            localparam int unsigned AW = $clog2(DEPTH);

            logic [DATA_W-1:0] mem_q [DEPTH];
            logic [DATA_W-1:0] mem_d [DEPTH];
            logic [AW:0]       wr_ptr_q, wr_ptr_d;
            logic [AW:0]       rd_ptr_q, rd_ptr_d;

            // Write into the slot being vacated is safe: the read uses the old contents.
            always_comb begin
                mem_d    = mem_q;
                wr_ptr_d = wr_ptr_q;
                rd_ptr_d = rd_ptr_q;
                if (push && (!full || pop)) begin
                    mem_d[wr_ptr_q[AW-1:0]] = push_data;
                    wr_ptr_d                = wr_ptr_q + (AW+1)'(1);
                end
                if (pop && !empty) begin
                    rd_ptr_d = rd_ptr_q + (AW+1)'(1);
                end
            end

            // Pointer and storage registers; storage needs no reset.
            always_ff @(posedge clk) begin
                if (rst) begin
                    wr_ptr_q <= '0;
                    rd_ptr_q <= '0;
                end else begin
                    wr_ptr_q <= wr_ptr_d;
                    rd_ptr_q <= rd_ptr_d;
                end
                mem_q <= mem_d;
            end

            assign empty    = (wr_ptr_q == rd_ptr_q);
            assign full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                              (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
            assign pop_data = mem_q[rd_ptr_q[AW-1:0]];
        end
    endgenerate

endmodule

// File: rtl/io_intr_bridge.sv
// Peripheral side of the CPU port interface: registered input port, edge-driven
// interrupt request with one-deep pending, and a queue draining CPU port writes.
// IO_OUT_FIFO_EN: queue is FIFO_DEPTH deep; otherwise a single holding register.
module io_intr_bridge
    import io_bridge_pkg::*;
#(
    parameter int unsigned DATA_W     = DEFAULT_DATA_W,
    parameter int unsigned FIFO_DEPTH = DEFAULT_FIFO_DEPTH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] cpu_o_port,
    input  logic              cpu_io_write,
    output logic [DATA_W-1:0] cpu_i_port,
    output logic              cpu_intr,
    input  logic              cpu_intr_ack,
    input  logic [DATA_W-1:0] ext_in,
    input  logic              ext_in_valid,
    input  logic              ext_irq,
    output logic [DATA_W-1:0] ext_out_data,
    output logic              ext_out_valid,
    input  logic              ext_out_ready,
    output logic              ovf_err
);

`ifdef IO_OUT_FIFO_EN
    localparam int unsigned Q_DEPTH = FIFO_DEPTH;
`else
    // FIFO_DEPTH has no effect in this build; referenced only to keep it consumed.
    localparam int unsigned Q_DEPTH = (FIFO_DEPTH != 0) ? 1 : 1;
`endif

    logic [DATA_W-1:0] cpu_i_port_q, cpu_i_port_d;
    logic              irq_q, irq_d;
    logic              pending_q, pending_d;
    logic              ovf_err_q, ovf_err_d;
    intr_state_e       state_q, state_d;
    logic              irq_rise;
    logic              q_full, q_empty, q_pop;

    assign irq_rise = ext_irq & ~irq_q;
    assign q_pop    = ~q_empty & ext_out_ready;

    // Input port capture, edge detector delay and sticky overflow.
    always_comb begin
        cpu_i_port_d = ext_in_valid ? ext_in : cpu_i_port_q;
        irq_d        = ext_irq;
        ovf_err_d    = ovf_err_q | (cpu_io_write & q_full & ~q_pop);
    end

    // Interrupt next-state; an edge while busy is remembered in pending, and
    // setting wins over the clear when both land in the same cycle.
    always_comb begin
        state_d   = state_q;
        pending_d = pending_q;
        unique case (state_q)
            IDLE: begin
                if (irq_rise || pending_q) begin
                    state_d   = REQ;
                    pending_d = 1'b0;
                end
            end
            REQ: begin
                if (cpu_intr_ack) begin
                    state_d = SERV;
                end
                if (irq_rise) begin
                    pending_d = 1'b1;
                end
            end
            SERV: begin
                if (!cpu_intr_ack) begin
                    if (pending_q) begin
                        state_d   = REQ;
                        pending_d = 1'b0;
                    end else begin
                        state_d = IDLE;
                    end
                end
                if (irq_rise) begin
                    pending_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // All top-level state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            cpu_i_port_q <= '0;
            irq_q        <= 1'b0;
            pending_q    <= 1'b0;
            ovf_err_q    <= 1'b0;
            state_q      <= IDLE;
        end else begin
            cpu_i_port_q <= cpu_i_port_d;
            irq_q        <= irq_d;
            pending_q    <= pending_d;
            ovf_err_q    <= ovf_err_d;
            state_q      <= state_d;
        end
    end

    io_out_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (Q_DEPTH)
    ) u_out_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (cpu_io_write),
        .push_data (cpu_o_port),
        .pop       (q_pop),
        .full      (q_full),
        .empty     (q_empty),
        .pop_data  (ext_out_data)
    );

    assign cpu_i_port    = cpu_i_port_q;
    assign cpu_intr      = (state_q == REQ);
    assign ext_out_valid = ~q_empty;
    assign ovf_err       = ovf_err_q;

endmodule

// File: tb/tb_io_intr_bridge.sv
// Bench for io_intr_bridge: directed stimulus, queue-drain scoreboard checked
// by an independent monitor, plus direct checks of port and interrupt outputs.
module tb_io_intr_bridge;

`ifdef IO_OUT_FIFO_EN
    localparam int QD = 4;
`else
    localparam int QD = 1;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] cpu_o_port;
    logic       cpu_io_write;
    logic [7:0] cpu_i_port;
    logic       cpu_intr;
    logic       cpu_intr_ack;
    logic [7:0] ext_in;
    logic       ext_in_valid;
    logic       ext_irq;
    logic [7:0] ext_out_data;
    logic       ext_out_valid;
    logic       ext_out_ready;
    logic       ovf_err;

    int total = 0;
    int bad   = 0;
    logic [7:0] exp_q[$];
    logic [7:0] vals [5] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};

    always #5 clk = ~clk;

    io_intr_bridge #(.DATA_W(8), .FIFO_DEPTH(4)) dut (
        .clk           (clk),
        .rst           (rst),
        .cpu_o_port    (cpu_o_port),
        .cpu_io_write  (cpu_io_write),
        .cpu_i_port    (cpu_i_port),
        .cpu_intr      (cpu_intr),
        .cpu_intr_ack  (cpu_intr_ack),
        .ext_in        (ext_in),
        .ext_in_valid  (ext_in_valid),
        .ext_irq       (ext_irq),
        .ext_out_data  (ext_out_data),
        .ext_out_valid (ext_out_valid),
        .ext_out_ready (ext_out_ready),
        .ovf_err       (ovf_err)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every accepted output beat must match the next expected value.
    always @(negedge clk) begin
        if (!rst && ext_out_valid && ext_out_ready) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL out_unexpected actual=%0h required=none", ext_out_data);
            end else begin
                chk("out_data", {24'h0, ext_out_data}, {24'h0, exp_q.pop_front()});
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; cpu_o_port = '0; cpu_io_write = 1'b0; cpu_intr_ack = 1'b0;
        ext_in = '0; ext_in_valid = 1'b0; ext_irq = 1'b0; ext_out_ready = 1'b0;
        tick(); tick();
        chk("rst_i_port", cpu_i_port, 0);
        chk("rst_intr", cpu_intr, 0);
        chk("rst_valid", ext_out_valid, 0);
        chk("rst_ovf", ovf_err, 0);
        rst = 1'b0;
        tick();

        // Input port capture and hold.
        ext_in = 8'hA5; ext_in_valid = 1'b1;
        chk("in_before", cpu_i_port, 0);
        tick();
        chk("in_load", cpu_i_port, 8'hA5);
        ext_in = 8'h5A; ext_in_valid = 1'b0;
        tick(); tick();
        chk("in_hold", cpu_i_port, 8'hA5);

        // Basic request, indefinite hold, three-cycle ack.
        ext_irq = 1'b1;
        chk("irq_pre", cpu_intr, 0);
        tick();
        chk("irq_req", cpu_intr, 1);
        repeat (5) tick();
        chk("irq_hold", cpu_intr, 1);
        cpu_intr_ack = 1'b1;
        tick();
        chk("ack_first", cpu_intr, 0);
        tick(); tick();
        chk("ack_third", cpu_intr, 0);
        cpu_intr_ack = 1'b0;
        tick(); tick();
        chk("idle_after_ack", cpu_intr, 0);
        ext_irq = 1'b0;
        tick();

        // One edge during service re-requests after ack drops.
        ext_irq = 1'b1; tick();
        chk("req2", cpu_intr, 1);
        ext_irq = 1'b0; cpu_intr_ack = 1'b1; tick();
        ext_irq = 1'b1; tick();
        ext_irq = 1'b0; tick();
        chk("serv_pend", cpu_intr, 0);
        cpu_intr_ack = 1'b0; tick();
        chk("rereq", cpu_intr, 1);
        cpu_intr_ack = 1'b1; tick();
        // Three edges during service coalesce into one re-request.
        for (int i = 0; i < 3; i++) begin
            ext_irq = 1'b1; tick();
            ext_irq = 1'b0; tick();
        end
        cpu_intr_ack = 1'b0; tick();
        chk("coalesce_req", cpu_intr, 1);
        cpu_intr_ack = 1'b1; tick();
        cpu_intr_ack = 1'b0; tick(); tick();
        chk("coalesce_once", cpu_intr, 0);

        // Edge coinciding with the pending clear keeps pending set.
        ext_irq = 1'b1; tick();
        ext_irq = 1'b0; cpu_intr_ack = 1'b1; tick();
        ext_irq = 1'b1; tick();
        ext_irq = 1'b0; tick();
        ext_irq = 1'b1; cpu_intr_ack = 1'b0; tick();
        chk("clr_set_req", cpu_intr, 1);
        ext_irq = 1'b0; cpu_intr_ack = 1'b1; tick();
        chk("clr_set_serv", cpu_intr, 0);
        cpu_intr_ack = 1'b0; tick();
        chk("clr_set_rereq", cpu_intr, 1);
        cpu_intr_ack = 1'b1; tick();
        cpu_intr_ack = 1'b0; tick(); tick();
        chk("clr_set_idle", cpu_intr, 0);

        // Fill past capacity with consumer stalled.
        for (int i = 0; i <= QD; i++) begin
            cpu_o_port = vals[i]; cpu_io_write = 1'b1;
            if (i == 0) chk("no_bypass", ext_out_valid, 0);
            if (i < QD) exp_q.push_back(vals[i]);
            tick();
            if (i == QD - 1) chk("ovf_not_yet", ovf_err, 0);
        end
        cpu_io_write = 1'b0;
        chk("ovf_set", ovf_err, 1);
        chk("full_valid", ext_out_valid, 1);
        repeat (3) tick();
        chk("stall_stable", ext_out_data, vals[0]);
        ext_out_ready = 1'b1;
        repeat (QD + 2) tick();
        chk("drain_done", exp_q.size(), 0);
        chk("drain_empty", ext_out_valid, 0);
        chk("ovf_sticky", ovf_err, 1);
        ext_out_ready = 1'b0;

        // Reset in the middle of a request and a partial queue.
        ext_irq = 1'b1; ext_in = 8'h3C; ext_in_valid = 1'b1; tick();
        ext_in_valid = 1'b0;
        cpu_o_port = 8'h77; cpu_io_write = 1'b1; tick();
        cpu_o_port = 8'h88; tick();
        cpu_io_write = 1'b0;
        chk("mid_intr", cpu_intr, 1);
        rst = 1'b1; tick();
        exp_q.delete();
        chk("mid_rst_i_port", cpu_i_port, 0);
        chk("mid_rst_intr", cpu_intr, 0);
        chk("mid_rst_valid", ext_out_valid, 0);
        chk("mid_rst_ovf", ovf_err, 0);
        rst = 1'b0; tick();
        chk("rst_release_edge", cpu_intr, 1);
        cpu_intr_ack = 1'b1; tick();
        cpu_intr_ack = 1'b0; ext_irq = 1'b0; tick();

        // Simultaneous push and pop while full.
        for (int i = 0; i < QD; i++) begin
            cpu_o_port = vals[i]; cpu_io_write = 1'b1;
            exp_q.push_back(vals[i]);
            tick();
        end
        cpu_o_port = 8'h66; ext_out_ready = 1'b1;
        exp_q.push_back(8'h66);
        tick();
        cpu_io_write = 1'b0;
        chk("pushpop_ovf", ovf_err, 0);
        repeat (QD + 2) tick();
        chk("pushpop_drained", exp_q.size(), 0);
        chk("pushpop_empty", ext_out_valid, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
